pb_uart_tx: RTL
===============

Name: pb_uart_tx

Overview:
PicoBlaze UART transmit stage, directly downstream of the UART register block. It consumes that block's buffer_write strobe, uart_data_write byte, enable and uart_clock_divide outputs. It buffers bytes in a small FIFO and serialises them as 8N1 frames on the tx pin. It returns the tx_data_present, tx_half_full and tx_full status flags that the register block reports in its status register.

Parameters:
FIFO_AW, 4, FIFO address width; depth DEPTH = 2**FIFO_AW (16 entries)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  transmitter enable from the register block
uart_clock_divide  input  16  bit period minus one, in clk cycles
buffer_write  input  1  push strobe; one byte pushed per cycle it is high
uart_data_write  input  8  byte to push, sampled when buffer_write=1
tx  output  1  serial line; idles high
tx_data_present  output  1  FIFO holds at least 1 byte
tx_half_full  output  1  FIFO count >= DEPTH/2
tx_full  output  1  FIFO count == DEPTH
tx_busy  output  1  serialiser is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1; tx_busy=0; tx_data_present=0; tx_half_full=0; tx_full=0.
  - FIFO pointers and count cleared to 0; baud counter 0; bit index 0; FSM in IDLE.
  - Reset mid-frame aborts the frame immediately. tx goes high without waiting for a clock edge, and buffered bytes are discarded.
- FIFO:
  - count register, width FIFO_AW+1, range 0..DEPTH; read/write pointers wrap modulo DEPTH.
  - Push when buffer_write=1 and tx_full=0. Push while tx_full=1 is dropped silently, even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Flags are registered and decoded from the next-state count, so they are valid the cycle after the push/pop edge.
- Baud timing:
  - Each bit lasts uart_clock_divide+1 clk cycles; divide=0 gives 1 cycle per bit.
  - baud_cnt increments every cycle outside IDLE.
  - A bit ends when baud_cnt >= uart_clock_divide; baud_cnt then returns to 0. A divide change mid-bit therefore takes effect without lockup.
- Serialiser FSM (tx registered):
  - IDLE: tx=1. If enable=1 and tx_data_present=1: pop the head byte into an 8-bit shift register, clear baud_cnt, go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. At each bit end, shift right and increment the index. After bit 7, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if enable=1 and tx_data_present=1, pop and go straight to START (no idle gap); otherwise go to IDLE.
  - tx_busy=1 in START, DATA and STOP.
- Latency: buffer_write high at edge N with FSM IDLE and enable=1 gives data_present=1 after N. The pop happens at N+1, and tx=0 (start bit) from after N+1.
- Frame length is exactly 10*(divide+1) cycles.
- enable=0 mid-frame: the current frame completes; no new frame starts. Pushes are still accepted while enable=0.
- Empty FIFO: no pop is ever issued; the FSM remains in IDLE.

Test Plan:
- Single frame: divide=3, enable=1, push 0xA5.
  - tx low 4 clk, then 1,0,1,0,0,1,0,1 at 4 clk each, then high 4 clk (40 clk total).
  - tx_busy high for exactly 40 clk; tx_data_present drops the cycle after the pop.
- Fill and overflow: enable=0, push 0x00..0x0F.
  - tx_half_full rises after the 8th push; tx_full rises after the 16th.
  - A 17th push of 0xFF is dropped.
  - Then enable=1: 16 frames transmitted in order 0x00..0x0F, and 0xFF never appears.
- Back-to-back: divide=0, push 0x01 and 0x80 on consecutive cycles, enable=1.
  - Frames are contiguous (stop bit of frame 1 followed immediately by start bit of frame 2), 20 clk total.
- Enable drop: divide=1, two bytes queued; deassert enable during frame 1 DATA.
  - Frame 1 completes; tx stays high and tx_busy=0.
  - tx_data_present stays 1 until enable is reasserted, then frame 2 is sent.
- Reset mid-frame: assert reset=0 during DATA bit 3 of 0x3C with 3 bytes queued.
  - tx=1 and all flags 0 immediately.
  - After release, no frames are sent until new pushes arrive.
- Simultaneous push/pop: FIFO count=1 in IDLE, enable=1; push on the pop cycle.
  - Count stays 1, tx_data_present stays 1, and both bytes are transmitted in order.

Source files
------------

// File: rtl/pb_uart_tx_if.sv
// rtl/pb_uart_tx_if.sv - register-block to UART transmitter bundle
interface pb_uart_tx_if;
  logic        enable;
  logic [15:0] uart_clock_divide;
  logic        buffer_write;
  logic [7:0]  uart_data_write;
  logic        tx;
  logic        tx_data_present;
  logic        tx_half_full;
  logic        tx_full;
  logic        tx_busy;

  modport master (
    output enable, uart_clock_divide, buffer_write, uart_data_write,
    input  tx, tx_data_present, tx_half_full, tx_full, tx_busy
  );

  modport slave (
    input  enable, uart_clock_divide, buffer_write, uart_data_write,
    output tx, tx_data_present, tx_half_full, tx_full, tx_busy
  );
endinterface

// File: rtl/pb_uart_tx.sv
// rtl/pb_uart_tx.sv - PicoBlaze UART transmitter: byte FIFO plus 8N1 serialiser
module pb_uart_tx #(
  parameter int FIFO_AW = 4
) (
  input logic         clk,
  input logic         reset,
  pb_uart_tx_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_HALF = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic               present_q, half_q, full_q;
  logic [7:0]         mem_q [DEPTH];
  logic               push, pop, bit_end;

  // A full FIFO refuses the byte even if a pop frees a slot this cycle.
  assign push    = bus.buffer_write && !full_q;
  assign bit_end = (baud_cnt_q >= bus.uart_clock_divide);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (state_q != IDLE) begin
      baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        if (bus.enable && present_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (bus.enable && present_q) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      present_q  <= 1'b0;
      half_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      present_q  <= (count_d != '0);
      half_q     <= (count_d >= CNT_HALF);
      full_q     <= (count_d == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.uart_data_write;
    end
  end

  assign bus.tx              = tx_q;
  assign bus.tx_busy         = (state_q != IDLE);
  assign bus.tx_data_present = present_q;
  assign bus.tx_half_full    = half_q;
  assign bus.tx_full         = full_q;
endmodule
